fpu_cmp_sched: RTL and testbench
================================

Name: fpu_cmp_sched

Overview:
- Round-robin scheduler that shares one single-precision float comparator among NUM_REQ requesters.
- Each requester issues compare/min/max operations through a valid/ready handshake.
- The block arbitrates, evaluates the selected pair through the comparator, and returns a registered result tagged with the requester ID.
- Sits between FPU issue ports (e.g. sort/reduction engines) and the compare datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester ID tag.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*32  operand A per requester, IEEE-754 single.
- req_b  in  NUM_REQ*32  operand B per requester.
- req_op  in  NUM_REQ*2  opcode per requester: 0=LT, 1=GE, 2=MIN, 3=MAX.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  ID_W  requester index of the result.
- rsp_data  out  32  LT/GE: 32'h1 if true, else 32'h0; MIN/MAX: the selected operand.

Behaviour:
- Reset (async, rst=1): rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0, round-robin pointer=0, slot state=EMPTY.
- Compare core (combinational), ge = A >= B:
  - A negative, B positive -> 0; A positive, B negative -> 1.
  - Both positive -> unsigned compare of {exp,mantissa}.
  - Both negative -> inverted compare; equal bit patterns -> 1.
  - +0 vs -0: ge=1 (A=+0, B=-0); ge=0 (A=-0, B=+0).
- Op results:
  - LT = !ge; GE = ge.
  - MIN = ge ? B : A; MAX = ge ? A : B.
- Output slot FSM, states EMPTY and FULL:
  - can_issue = (state==EMPTY) || (rsp_valid && rsp_ready).
  - EMPTY -> FULL on issue.
  - FULL -> EMPTY on rsp_ready without a new issue.
  - FULL -> FULL on rsp_ready with a simultaneous issue: new result loaded, no bubble.
- Arbitration:
  - When can_issue, grant the first requester with req_valid set, searching from ptr upward with wrap-around (NUM_REQ-1 wraps to 0).
  - req_ready[g]=1 only for the granted index, in the same cycle.
  - Transfer occurs when req_valid[g] && req_ready[g].
  - ptr <= g+1 (mod NUM_REQ) on each transfer; ptr is unchanged if nothing is issued.
- Latency: operation accepted in cycle N -> rsp_valid high in cycle N+1.
  - Throughput is 1 op/cycle when rsp_ready is held high.
- While FULL and rsp_ready=0: rsp_valid, rsp_id and rsp_data stay stable, and all req_ready bits are 0.
- Requesters must hold a_/b_/op stable while valid and not accepted; the block does not sample un-granted inputs.
- A requester is never starved: at most NUM_REQ-1 other grants occur between its req_valid rising and its acceptance.
- rst asserted mid-operation drops any held result immediately; no response is produced for it.

Optional Feature:
- Macro: FPU_CMP_NAN_EN.
- Defined:
  - Exponent 0xFF with a non-zero mantissa marks an operand as NaN.
  - If either operand is NaN: LT and GE return 0.
  - MIN/MAX return the non-NaN operand, or canonical 32'h7FC00000 if both are NaN.
  - Extra output port rsp_nan (1 bit) is registered alongside rsp_data, reset 0, and set when any operand was NaN.
- Undefined: pure bit-pattern ordering as above; no rsp_nan port.

Decomposition:
- Package fpu_cmp_pkg:
  - cmp_op_e enum (CMP_LT, CMP_GE, CMP_MIN, CMP_MAX).
  - Constants CANON_NAN=32'h7FC00000 and TRUE_W=32'h1.
- One sub-module fpu_cmp_core: combinational, inputs a, b, op; outputs result[31:0] (and nan when FPU_CMP_NAN_EN).
- The scheduler holds the arbiter, pointer, output slot FSM and registers.

Test Plan:
- Single requester 0, op=LT, A=32'h3F800000 (1.0), B=32'h40000000 (2.0), rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=32'h1.
- All 4 requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,…, one rsp per cycle, no bubbles.
- Requester 2, MIN, A=32'hC0000000 (-2.0), B=32'hBF800000 (-1.0) -> rsp_data=32'hC0000000.
  - MAX with the same operands -> rsp_data=32'hBF800000.
- Output stalls (rsp_ready=0) for 5 cycles after one result -> rsp_valid, rsp_id, rsp_data stable; req_ready=0.
  - Release rsp_ready -> a new grant issues in the same cycle; next result follows one cycle later.
- With FPU_CMP_NAN_EN: GE with A=32'h7FC00001, B=32'h00000000 -> rsp_data=0, rsp_nan=1.
  - MAX with both operands NaN -> rsp_data=32'h7FC00000.
- Assert rst for one cycle while FULL -> rsp_valid=0 asynchronously; ptr=0; after release, requester 0 wins first grant when all are valid.

Source files
------------

// File: rtl/fpu_cmp_pkg.sv
// Shared types and constants for the shared float comparator scheduler.
// Optional NaN handling is enabled by defining FPU_CMP_NAN_EN.
package fpu_cmp_pkg;

  typedef enum logic [1:0] {
    CMP_LT  = 2'd0,
    CMP_GE  = 2'd1,
    CMP_MIN = 2'd2,
    CMP_MAX = 2'd3
  } cmp_op_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam logic [31:0] TRUE_W    = 32'h0000_0001;

  function automatic logic is_nan(input logic [31:0] v);
    return (&v[30:23]) && (|v[22:0]);
  endfunction

endpackage

// File: rtl/fpu_cmp_sched_if.sv
// Requester/consumer bundle for fpu_cmp_sched: per-requester valid/ready ops in, tagged result out.
// rsp_nan exists only when FPU_CMP_NAN_EN is defined.
interface fpu_cmp_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][31:0] req_a;
  logic [NUM_REQ-1:0][31:0] req_b;
  logic [NUM_REQ-1:0][1:0]  req_op;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [31:0]              rsp_data;
`ifdef FPU_CMP_NAN_EN
  logic                     rsp_nan;
`endif

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
`ifdef FPU_CMP_NAN_EN
    , input rsp_nan
`endif
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
`ifdef FPU_CMP_NAN_EN
    , output rsp_nan
`endif
  );
endinterface

// File: rtl/fpu_cmp_core.sv
// Combinational single-precision compare/min/max; zero latency, no backpressure.
// FPU_CMP_NAN_EN adds NaN detection and IEEE-style NaN results.
module fpu_cmp_core
  import fpu_cmp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  cmp_op_e     op,
  output logic [31:0] result
`ifdef FPU_CMP_NAN_EN
  , output logic      nan
`endif
);

  logic ge;

  // Sign-magnitude ordering: negative pairs order inversely, so -0 < +0.
  always_comb begin
    ge = 1'b0;
    if (a[31] != b[31]) begin
      ge = b[31];
    end else if (!a[31]) begin
      ge = (a[30:0] >= b[30:0]);
    end else begin
      ge = (a[30:0] <= b[30:0]);
    end
  end

`ifdef FPU_CMP_NAN_EN
  logic a_nan;
  logic b_nan;
  assign a_nan = is_nan(a);
  assign b_nan = is_nan(b);
  assign nan   = a_nan || b_nan;
`endif

  always_comb begin
    result = '0;
    case (op)
      CMP_LT:  result = ge ? '0 : TRUE_W;
      CMP_GE:  result = ge ? TRUE_W : '0;
      CMP_MIN: result = ge ? b : a;
      CMP_MAX: result = ge ? a : b;
      default: result = '0;
    endcase
`ifdef FPU_CMP_NAN_EN
    if (a_nan || b_nan) begin
      if (op == CMP_LT || op == CMP_GE) begin
        result = '0;
      end else if (a_nan && b_nan) begin
        result = CANON_NAN;
      end else if (a_nan) begin
        result = b;
      end else begin
        result = a;
      end
    end
`endif
  end

endmodule

// File: rtl/fpu_cmp_sched.sv
// Round-robin share of one float comparator; 1-cycle latency, 1 op/cycle with rsp_ready high.
// A held result stalls all grants until consumed; FPU_CMP_NAN_EN adds rsp_nan.
module fpu_cmp_sched
  import fpu_cmp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic           clk,
  input  logic           rst,
  fpu_cmp_sched_if.slave bus
);

  slot_state_e     state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
`ifdef FPU_CMP_NAN_EN
  logic            rsp_nan_q, rsp_nan_d;
  logic            core_nan;
`endif

  logic            can_issue;
  logic            gnt_vld;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand_id;
  logic            issue;
  logic [31:0]     core_res;

  assign can_issue = (state_q == SLOT_EMPTY) || bus.rsp_ready;
  assign issue     = can_issue && gnt_vld && !rst;

  // First valid requester at or after ptr, wrapping past NUM_REQ-1.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_id = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!gnt_vld && bus.req_valid[cand_id]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_id;
      end
    end
  end

  fpu_cmp_core u_core (
    .a      (bus.req_a[gnt_idx]),
    .b      (bus.req_b[gnt_idx]),
    .op     (cmp_op_e'(bus.req_op[gnt_idx])),
    .result (core_res)
`ifdef FPU_CMP_NAN_EN
    , .nan  (core_nan)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SLOT_EMPTY;
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
`ifdef FPU_CMP_NAN_EN
      rsp_nan_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
`ifdef FPU_CMP_NAN_EN
      rsp_nan_q  <= rsp_nan_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (issue) state_d = SLOT_FULL;
      SLOT_FULL:  if (bus.rsp_ready && !issue) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
`ifdef FPU_CMP_NAN_EN
    rsp_nan_d  = rsp_nan_q;
`endif
    if (issue) begin
      ptr_d      = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      rsp_id_d   = gnt_idx;
      rsp_data_d = core_res;
`ifdef FPU_CMP_NAN_EN
      rsp_nan_d  = core_nan;
`endif
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (issue) bus.req_ready[gnt_idx] = 1'b1;
    bus.rsp_valid = (state_q == SLOT_FULL);
    bus.rsp_id    = rsp_id_q;
    bus.rsp_data  = rsp_data_q;
`ifdef FPU_CMP_NAN_EN
    bus.rsp_nan   = rsp_nan_q;
`endif
  end

endmodule

// File: tb/tb_fpu_cmp_sched.sv
// Bench for fpu_cmp_sched: directed literal cases plus randomized traffic vs. a float-ordering model.
module tb_fpu_cmp_sched;
  localparam int N = 4;

  logic clk;
  logic rst;
  fpu_cmp_sched_if #(.NUM_REQ(N)) bus ();

  fpu_cmp_sched #(.NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] pv;
  logic [31:0]  pa [N];
  logic [31:0]  pb [N];
  logic [1:0]   pop [N];
  logic [N-1:0] acc;

  // Model state
  bit          m_full;
  int          m_id;
  logic [31:0] m_data;
  bit          m_nan;
  int          m_ptr;
  int          wait_cnt [N];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Float order as an integer key: negatives mirrored below zero, -0 just below +0.
  function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    longint ka, kb;
    bit ge, an, bn;
    logic [31:0] r;
    ka = a[31] ? (-longint'({33'd0, a[30:0]}) - 1) : longint'({33'd0, a[30:0]});
    kb = b[31] ? (-longint'({33'd0, b[30:0]}) - 1) : longint'({33'd0, b[30:0]});
    ge = (ka >= kb);
    case (op)
      2'd0:    r = {31'd0, !ge};
      2'd1:    r = {31'd0, ge};
      2'd2:    r = ge ? b : a;
      default: r = ge ? a : b;
    endcase
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
`ifdef FPU_CMP_NAN_EN
    if (an || bn) r = (op < 2'd2) ? 32'd0 : (an && bn) ? 32'h7FC00000 : an ? b : a;
`endif
    return {an || bn, r};
  endfunction

  always @(negedge clk) begin : cmp_p
    int g;
    int idx;
    logic [N-1:0] exp_rdy;
    logic [32:0] res;
    if (rst) begin
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      m_full = 0;
      m_ptr  = 0;
      acc    = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      g = -1;
      exp_rdy = '0;
      if (!m_full || bus.rsp_ready) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && bus.req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", bus.req_ready, exp_rdy);
      check("rsp_valid", bus.rsp_valid, m_full);
      if (m_full) begin
        check("rsp_id", bus.rsp_id, m_id);
        check("rsp_data", bus.rsp_data, m_data);
`ifdef FPU_CMP_NAN_EN
        check("rsp_nan", bus.rsp_nan, m_nan);
`endif
      end
      if (m_full && bus.rsp_ready) m_full = 0;
      acc = exp_rdy;
      if (g >= 0) begin
        check("starve_bound", (wait_cnt[g] <= N - 1), 1);
        res    = ref_op(bus.req_a[g], bus.req_b[g], bus.req_op[g]);
        m_full = 1;
        m_id   = g;
        m_data = res[31:0];
        m_nan  = res[32];
        m_ptr  = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] || i == g) wait_cnt[i] = 0;
        else if (g >= 0) wait_cnt[i]++;
      end
    end
  end

  task automatic drive();
    bus.req_valid = pv;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i]  = pa[i];
      bus.req_b[i]  = pb[i];
      bus.req_op[i] = pop[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pv = pv & ~acc;
    drive();
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 9))
      0: return 32'h00000000;
      1: return 32'h80000000;
      2: return 32'h3F800000;
      3: return 32'hBF800000;
      4: return 32'h7F800000;
      5: return 32'hFF800000;
      6: return 32'h7FC00001;
      7: return 32'hFFC00000;
      default: return $urandom;
    endcase
  endfunction

  task automatic load_rand(input int i);
    pv[i]  = 1'b1;
    pa[i]  = rand_opnd();
    pb[i]  = ($urandom_range(0, 7) == 0) ? pa[i] : rand_opnd();
    pop[i] = 2'($urandom_range(0, 3));
  endtask

  // Single-requester op, accepted at once; result checked against a literal.
  task automatic run1(input int idx, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [31:0] exp, input string nm);
    pv[idx] = 1'b1; pa[idx] = a; pb[idx] = b; pop[idx] = op;
    bus.rsp_ready = 1'b1;
    drive();
    step();
    check({nm, "_vld"}, bus.rsp_valid, 1);
    check({nm, "_id"}, bus.rsp_id, idx);
    check({nm, "_dat"}, bus.rsp_data, exp);
  endtask

  initial begin
    rst = 1'b1;
    pv = '1;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      pa[i] = '0; pb[i] = '0; pop[i] = '0;
    end
    bus.rsp_ready = 1'b0;
    drive();
    #2;
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_id", bus.rsp_id, 0);
    check("reset_rsp_data", bus.rsp_data, 0);
    check("reset_req_ready", bus.req_ready, 0);
`ifdef FPU_CMP_NAN_EN
    check("reset_rsp_nan", bus.rsp_nan, 0);
`endif
    pv = '0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run1(0, 32'h3F800000, 32'h40000000, 2'd0, 32'h1, "lt_1_2");
    run1(1, 32'h00000000, 32'h80000000, 2'd1, 32'h1, "ge_pz_nz");
    run1(3, 32'h80000000, 32'h00000000, 2'd1, 32'h0, "ge_nz_pz");
    run1(2, 32'hC0000000, 32'hBF800000, 2'd2, 32'hC0000000, "min_neg");
    run1(2, 32'hC0000000, 32'hBF800000, 2'd3, 32'hBF800000, "max_neg");

    // Output stall: hold result, no grants, then release with a same-cycle grant.
    run1(1, 32'h3F800000, 32'h3F800000, 2'd1, 32'h1, "ge_eq");
    bus.rsp_ready = 1'b0;
    pv[3] = 1'b1; pa[3] = 32'hBF800000; pb[3] = 32'h00000000; pop[3] = 2'd0;
    drive();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_vld", bus.rsp_valid, 1);
      check("stall_id", bus.rsp_id, 1);
      check("stall_dat", bus.rsp_data, 1);
      check("stall_rdy", bus.req_ready, 0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("release_rdy", bus.req_ready, 4'b1000);
    step();
    check("release_id", bus.rsp_id, 3);
    check("release_dat", bus.rsp_data, 1);

`ifdef FPU_CMP_NAN_EN
    run1(0, 32'h7FC00001, 32'h00000000, 2'd1, 32'h0, "nan_ge");
    check("nan_flag", bus.rsp_nan, 1);
    run1(2, 32'h7FC00001, 32'hFFC00000, 2'd3, 32'h7FC00000, "nan_max2");
`endif

    // Reset while holding a result, then round-robin from requester 0.
    run1(2, 32'h40000000, 32'h3F800000, 2'd3, 32'h40000000, "pre_rst");
    bus.rsp_ready = 1'b0;
    drive();
    #1 rst = 1'b1;
    #1;
    check("async_rst_vld", bus.rsp_valid, 0);
    check("async_rst_rdy", bus.req_ready, 0);
    for (int i = 0; i < N; i++) load_rand(i);
    bus.rsp_ready = 1'b1;
    drive();
    step();
    rst = 1'b0;
    #1;
    check("post_rst_gnt", bus.req_ready, 4'b0001);
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_vld", bus.rsp_valid, 1);
      check("rr_id", bus.rsp_id, k % N);
      for (int i = 0; i < N; i++) if (!pv[i]) load_rand(i);
      drive();
    end

    // Randomized traffic with random consumer backpressure.
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < N; i++) if (!pv[i] && $urandom_range(0, 2) == 0) load_rand(i);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      drive();
    end

    pv = '0;
    bus.rsp_ready = 1'b1;
    drive();
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
